solve_scheduler: RTL
====================

// Module: solve_scheduler
// PURPOSE
//  Feeds tagged Othello positions into the multi-slot solver pipeline and returns tagged results.
//  Sits between the host-side task stream and the pipeline. It owns the pipeline enable.
//  It tracks which task occupies each pipeline slot and reserves result space before dispatching a task.
//  The pipeline restarts every slot whenever its enable drops, so the scheduler never back-pressures it.
// PARAMETERS
//  NSLOTS    7   pipeline thread slots (slot ids 0..NSLOTS-1)
//  TAG_W     16  task tag width
//  RES_DEPTH 8   result FIFO depth (power of 2, >= NSLOTS)
// PORTS
//  iCLOCK       in  1      clock
//  iRESET_N     in  1      asynchronous active-low reset
//  run          in  1      level; 1 = run, 0 = request drain and stop
//  in_valid     in  1      task valid
//  in_ready     out 1      task accepted when in_valid & in_ready
//  in_player    in  64     side-to-move discs
//  in_opponent  in  64     other side's discs
//  in_tag       in  TAG_W  task tag
//  pipe_enable  out 1      pipeline enable
//  pipe_player  out 64     position presented to the pipeline
//  pipe_opponent out 64    position presented to the pipeline
//  pipe_solved  in  1      a slot finished and loaded the presented position on this edge
//  pipe_slot    in  4      slot id qualifying pipe_solved and the warm-up loads
//  pipe_res     in  8      signed final score, valid with pipe_solved
//  out_valid    out 1      result valid
//  out_ready    in  1      result accepted when out_valid & out_ready
//  out_tag      out TAG_W  result tag
//  out_score    out 8      signed result score, range -64..64
//  busy         out 1      state != IDLE
// BEHAVIOUR
//  Reset values: every output 0; FIFO empty; slot table all invalid; state IDLE.
//  Hold register: one entry. in_ready = ~hold_valid. A task is dispatched only from the hold register.
//  Presented position:
//   - If hold_valid & credit > 0 & state==RUN: the hold register.
//   - Otherwise the dummy: player = 64'hFFFF_FFFF_FFFF_FFFF, opponent = 0 (full board, solves immediately).
//  Credit: credit = RES_DEPTH - fifo_count - inflight, where inflight = number of valid slot-table entries.
//   - Credit never goes negative.
//  Load event: pipe_solved=1, or a warm-up cycle. The loaded slot is pipe_slot.
//   - Dispatching: table[slot] <= {1, hold_tag}; hold_valid <= 0.
//   - Not dispatching: table[slot] <= {0, x}.
//  Solve event (pipe_solved=1): if the old table[slot] is valid, push {tag, pipe_res} into the FIFO.
//   - The result uses the pre-update entry; the same-cycle reload of that slot writes after the read.
//   - A push can never find the FIFO full; a full-FIFO push is an assertion failure.
//  FSM:
//   - IDLE: pipe_enable=0. Goes to WARMUP when run=1.
//   - WARMUP: pipe_enable=1 for NSLOTS cycles, counted by a 3-bit counter. Each cycle is a load event. Then RUN.
//   - RUN: dispatch as above. Goes to DRAIN when run=0.
//   - DRAIN: present only the dummy. When inflight==0, go to IDLE (pipe_enable drops next cycle).
//     If run returns to 1 in DRAIN, go back to RUN without a warm-up.
//  FIFO output is standard valid/ready: first-word-fall-through, 1-cycle push-to-out_valid latency, results in solve order (not tag order).
//  Async reset mid-operation: abandons all in-flight tasks. No result is emitted for them.
// CONFIGURATION
//  SCHED_PERF_EN defined:
//   - Adds outputs perf_busy_cyc[31:0], perf_done[31:0] and perf_idle_loads[31:0].
//   - Counters saturate, reset to 0 and count only while pipe_enable=1.
//   - perf_done counts results pushed. perf_idle_loads counts dummy loads in RUN.
//  SCHED_PERF_EN undefined: these ports and counters do not exist. All other behaviour is identical.
// STRUCTURE
//  Package othello_sched_pkg:
//   - NSLOTS_MAX=16.
//   - slot_entry_t {valid, tag}.
//   - result_t {tag, score}.
//   - sched_state_e {IDLE, WARMUP, RUN, DRAIN}.
//   - DUMMY_PLAYER / DUMMY_OPPONENT constants.
//  Sub-module sched_result_fifo: parameterised synchronous FIFO of result_t with count output.
// TESTING
//  1. Reset, run=1, no tasks: WARMUP 7 cycles with dummy presented.
//     Then, in RUN with the dummy presented, the stubbed pipeline solves the dummy loads → out_valid stays 0; busy=1.
//  2. One task, tag 0x0005, loaded at slot 3; stub returns pipe_solved with slot 3 and res=+12 → out_tag=0x0005, out_score=12, one beat.
//  3. 10 tasks with out_ready=0, RES_DEPTH=8 → exactly 8 dispatched, then only the dummy is presented.
//     in_ready stays low with the 9th task held. After 3 pops, dispatch resumes.
//  4. Slot 2 solves (old tag 0xA) and reloads with new tag 0xB on the same edge → result tag 0xA; later solve of slot 2 returns 0xB.
//  5. run=0 with 3 in flight → DRAIN, only the dummy presented, 3 results emitted, then IDLE and pipe_enable=0.
//  6. iRESET_N low mid-RUN with tasks in flight → all outputs 0 at once, no results after release, FIFO empty.

Source files
------------

// File: rtl/othello_sched_pkg.sv
// Shared types and constants for the Othello solve scheduler and its result FIFO.
package othello_sched_pkg;

  localparam int unsigned NSLOTS_MAX = 16;
  localparam int unsigned TAG_W_MAX  = 16;

  // Full board: the pipeline finishes this position immediately.
  localparam logic [63:0] DUMMY_PLAYER   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] DUMMY_OPPONENT = 64'h0000_0000_0000_0000;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
  } slot_entry_t;

  typedef struct packed {
    logic [TAG_W_MAX-1:0] tag;
    logic signed [7:0]    score;
  } result_t;

  typedef enum logic [1:0] {
    StIdle,
    StWarmup,
    StRun,
    StDrain
  } sched_state_e;

endpackage

// File: rtl/sched_result_fifo.sv
// First-word-fall-through result FIFO with occupancy count; Depth must be a power of 2.
module sched_result_fifo
  import othello_sched_pkg::*;
#(
  parameter int unsigned Depth = 8,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_push,
  input  result_t        i_data,
  input  logic           i_pop,
  output logic           o_valid,
  output result_t        o_data,
  output logic [AddrW:0] o_count
);

  result_t          r_mem [Depth];
  logic [AddrW-1:0] r_wptr;
  logic [AddrW-1:0] r_rptr;
  logic [AddrW:0]   r_count;
  logic             w_pop;

  assign w_pop   = i_pop & (r_count != '0);
  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AddrW'(1);
      if (w_pop)  r_rptr <= r_rptr + AddrW'(1);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + (AddrW + 1)'(1);
        2'b01:   r_count <= r_count - (AddrW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  // Credit accounting upstream guarantees room for every push.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && (r_count == (AddrW + 1)'(Depth))));

endmodule

// File: rtl/solve_scheduler.sv
// Dispatches tagged positions into the multi-slot solver pipeline and returns tagged results.
// Optional performance counters are enabled by defining SCHED_PERF_EN.
module solve_scheduler
  import othello_sched_pkg::*;
#(
  parameter int unsigned NSLOTS    = 7,
  parameter int unsigned TAG_W     = 16,
  parameter int unsigned RES_DEPTH = 8
) (
  input  logic             iCLOCK,
  input  logic             iRESET_N,
  input  logic             run,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_player,
  input  logic [63:0]      in_opponent,
  input  logic [TAG_W-1:0] in_tag,
  output logic             pipe_enable,
  output logic [63:0]      pipe_player,
  output logic [63:0]      pipe_opponent,
  input  logic             pipe_solved,
  input  logic [3:0]       pipe_slot,
  input  logic [7:0]       pipe_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [7:0]       out_score,
`ifdef SCHED_PERF_EN
  output logic [31:0]      perf_busy_cyc,
  output logic [31:0]      perf_done,
  output logic [31:0]      perf_idle_loads,
`endif
  output logic             busy
);

  localparam int unsigned CntW = $clog2(RES_DEPTH) + 1;

  sched_state_e     r_state;
  sched_state_e     w_state_next;
  logic [2:0]       r_warm_cnt;
  logic             r_alive;
  logic             r_hold_valid;
  logic [63:0]      r_hold_player;
  logic [63:0]      r_hold_opponent;
  logic [TAG_W-1:0] r_hold_tag;
  slot_entry_t      r_table [NSLOTS_MAX];

  logic [4:0]       w_inflight;
  logic [CntW-1:0]  w_fifo_count;
  logic [5:0]       w_used;
  logic             w_has_credit;
  logic             w_active;
  logic             w_slot_ok;
  logic             w_present_hold;
  logic             w_load;
  logic             w_dispatch;
  logic             w_push;
  logic             w_accept;
  logic             w_fifo_valid;
  result_t          w_push_data;
  result_t          w_fifo_data;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < int'(NSLOTS); i++) begin
      w_inflight = w_inflight + 5'(r_table[i].valid);
    end
  end

  assign w_used       = 6'(w_fifo_count) + 6'(w_inflight);
  assign w_has_credit = (w_used < 6'(RES_DEPTH));
  assign w_active     = (r_state == StRun) || (r_state == StDrain);
  assign w_slot_ok    = ({1'b0, pipe_slot} < 5'(NSLOTS));

  assign w_present_hold = r_hold_valid & w_has_credit & (r_state == StRun);
  assign w_load         = ((r_state == StWarmup) | (pipe_solved & w_active)) & w_slot_ok;
  assign w_dispatch     = w_load & w_present_hold;
  // The result reads the entry before this edge's reload overwrites it.
  assign w_push         = pipe_solved & w_active & w_slot_ok & r_table[pipe_slot].valid;
  assign w_push_data    = '{tag: r_table[pipe_slot].tag, score: pipe_res};
  assign w_accept       = in_valid & in_ready;

  // r_alive keeps in_ready and the presented position at 0 while reset is asserted.
  always_ff @(posedge iCLOCK or negedge iRESET_N) begin
    if (!iRESET_N) r_alive <= 1'b0;
    else           r_alive <= 1'b1;
  end

  always_ff @(posedge iCLOCK or negedge iRESET_N) begin
    if (!iRESET_N) r_state <= StIdle;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (run) w_state_next = StWarmup;
      StWarmup: if (r_warm_cnt == 3'(NSLOTS - 1)) w_state_next = StRun;
      StRun:    if (!run) w_state_next = StDrain;
      StDrain: begin
        if (run)                   w_state_next = StRun;
        else if (w_inflight == '0) w_state_next = StIdle;
      end
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    pipe_enable   = 1'b0;
    in_ready      = 1'b0;
    pipe_player   = '0;
    pipe_opponent = '0;
    if (r_alive) begin
      pipe_enable = (r_state != StIdle);
      in_ready    = ~r_hold_valid;
      if (w_present_hold) begin
        pipe_player   = r_hold_player;
        pipe_opponent = r_hold_opponent;
      end else begin
        pipe_player   = DUMMY_PLAYER;
        pipe_opponent = DUMMY_OPPONENT;
      end
    end
  end

  assign busy = (r_state != StIdle);

  always_ff @(posedge iCLOCK or negedge iRESET_N) begin
    if (!iRESET_N)                 r_warm_cnt <= '0;
    else if (r_state == StWarmup) r_warm_cnt <= r_warm_cnt + 3'd1;
    else                          r_warm_cnt <= '0;
  end

  always_ff @(posedge iCLOCK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      r_hold_valid    <= 1'b0;
      r_hold_player   <= '0;
      r_hold_opponent <= '0;
      r_hold_tag      <= '0;
    end else if (w_accept) begin
      r_hold_valid    <= 1'b1;
      r_hold_player   <= in_player;
      r_hold_opponent <= in_opponent;
      r_hold_tag      <= in_tag;
    end else if (w_dispatch) begin
      r_hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge iCLOCK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      for (int i = 0; i < int'(NSLOTS_MAX); i++) r_table[i] <= '0;
    end else if (w_load) begin
      if (w_dispatch) r_table[pipe_slot] <= '{valid: 1'b1, tag: TAG_W_MAX'(r_hold_tag)};
      else            r_table[pipe_slot] <= '0;
    end
  end

  sched_result_fifo #(
    .Depth(RES_DEPTH)
  ) u_result_fifo (
    .i_clk  (iCLOCK),
    .i_rst_n(iRESET_N),
    .i_push (w_push),
    .i_data (w_push_data),
    .i_pop  (out_ready),
    .o_valid(w_fifo_valid),
    .o_data (w_fifo_data),
    .o_count(w_fifo_count)
  );

  assign out_valid = w_fifo_valid;
  assign out_tag   = w_fifo_valid ? w_fifo_data.tag[TAG_W-1:0] : '0;
  assign out_score = w_fifo_valid ? w_fifo_data.score : '0;

`ifdef SCHED_PERF_EN
  logic [31:0] r_perf_busy;
  logic [31:0] r_perf_done;
  logic [31:0] r_perf_idle;

  always_ff @(posedge iCLOCK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      r_perf_busy <= '0;
      r_perf_done <= '0;
      r_perf_idle <= '0;
    end else if (pipe_enable) begin
      if (r_perf_busy != '1) r_perf_busy <= r_perf_busy + 32'd1;
      if (w_push && r_perf_done != '1) r_perf_done <= r_perf_done + 32'd1;
      if (w_load && (r_state == StRun) && !w_dispatch && r_perf_idle != '1) begin
        r_perf_idle <= r_perf_idle + 32'd1;
      end
    end
  end

  assign perf_busy_cyc   = r_perf_busy;
  assign perf_done       = r_perf_done;
  assign perf_idle_loads = r_perf_idle;
`endif

endmodule
